// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the core load/store path (C)
// and the DMA/program loader (D), with anti-starvation and bounded DMA bursts.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic [3:0]    c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_lock,
    input  logic [3:0]    d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic [3:0]    mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          dma_owner
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [WW-1:0] WAIT_MAX   = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } state_t;

    state_t        state, state_n;
    logic [WW-1:0] wait_cnt, wait_n;
    logic [BW-1:0] burst_cnt, burst_n;
    logic          d_win;

    // Core wins by default; D wins while it owns the bus, when the core is idle,
    // or once it has been denied MAX_WAIT times in a row.
    always_comb begin
        d_win = d_req & ((state == OWN_D) | ~c_req | (wait_cnt == WAIT_MAX));
        d_gnt = d_win;
        c_gnt = c_req & ~d_win;
        if (d_win) begin
            mem_addr = d_addr;
            mem_din  = d_wdata;
            mem_we   = d_we;
        end else begin
            mem_addr = c_addr;
            mem_din  = c_wdata;
            mem_we   = c_gnt ? c_we : 4'b0000;
        end
    end

    always_comb begin
        state_n = state;
        burst_n = burst_cnt;
        wait_n  = wait_cnt;
        if (d_win) begin
            wait_n = '0;
            if (d_lock && (burst_cnt < BURST_LAST)) begin
                state_n = OWN_D;
                burst_n = burst_cnt + 1'b1;
            end else begin
                state_n = OWN_C;
                burst_n = '0;
            end
        end else begin
            if (d_req && (wait_cnt != WAIT_MAX)) begin
                wait_n = wait_cnt + 1'b1;
            end
            // Only reachable with d_req low: an owning DMA always wins otherwise.
            if (state == OWN_D) begin
                state_n = OWN_C;
                burst_n = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= OWN_C;
            wait_cnt  <= '0;
            burst_cnt <= '0;
            c_rvalid  <= 1'b0;
            d_rvalid  <= 1'b0;
        end else begin
            state     <= state_n;
            wait_cnt  <= wait_n;
            burst_cnt <= burst_n;
            c_rvalid  <= c_gnt & (c_we == 4'b0000);
            d_rvalid  <= d_gnt & (d_we == 4'b0000);
        end
    end

    assign c_rdata   = mem_dout;
    assign d_rdata   = mem_dout;
    assign dma_owner = (state == OWN_D);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-enabled
// synchronous-read memory model behind the arbiter.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        c_req;
    logic [3:0]  c_we;
    logic [31:0] c_addr;
    logic [31:0] c_wdata;
    logic        c_gnt;
    logic        c_rvalid;
    logic [31:0] c_rdata;
    logic        d_req;
    logic        d_lock;
    logic [3:0]  d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [3:0]  mem_we;
    logic [31:0] mem_dout;
    logic        dma_owner;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] mem [0:255];

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(4), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_lock(d_lock), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .dma_owner(dma_owner)
    );

    always #5 clk = ~clk;

    // Memory contents are reloaded whenever reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mem[8'h40] <= 32'h1111_2222;
            mem[8'h41] <= 32'h3333_4444;
        end else begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) mem[mem_addr[9:2]][8*b +: 8] <= mem_din[8*b +: 8];
        end
        mem_dout <= mem[mem_addr[9:2]];
    end

    task automatic idle_inputs();
        c_req = 1'b0; c_we = 4'b0; c_addr = 32'h0; c_wdata = 32'h0;
        d_req = 1'b0; d_lock = 1'b0; d_we = 4'b0; d_addr = 32'h0; d_wdata = 32'h0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (c_gnt !== 1'b0)     begin n_err++; $display("[TB] FAIL rst_c_gnt got %b want 0", c_gnt); end
        n_cmp++; if (d_gnt !== 1'b0)     begin n_err++; $display("[TB] FAIL rst_d_gnt got %b want 0", d_gnt); end
        n_cmp++; if (c_rvalid !== 1'b0)  begin n_err++; $display("[TB] FAIL rst_c_rvalid got %b want 0", c_rvalid); end
        n_cmp++; if (d_rvalid !== 1'b0)  begin n_err++; $display("[TB] FAIL rst_d_rvalid got %b want 0", d_rvalid); end
        n_cmp++; if (dma_owner !== 1'b0) begin n_err++; $display("[TB] FAIL rst_owner got %b want 0", dma_owner); end
        n_cmp++; if (mem_we !== 4'b0)    begin n_err++; $display("[TB] FAIL rst_mem_we got %b want 0000", mem_we); end
        n_cmp++; if (dut.wait_cnt !== 3'd0)  begin n_err++; $display("[TB] FAIL rst_wait got %0d want 0", dut.wait_cnt); end
        n_cmp++; if (dut.burst_cnt !== 3'd0) begin n_err++; $display("[TB] FAIL rst_burst got %0d want 0", dut.burst_cnt); end
    endtask

    task automatic test_core_reads();
        @(negedge clk); c_req = 1'b1; c_we = 4'b0; c_addr = 32'h100; #1;
        n_cmp++; if (c_gnt !== 1'b1)        begin n_err++; $display("[TB] FAIL crd0_c_gnt got %b want 1", c_gnt); end
        n_cmp++; if (d_gnt !== 1'b0)        begin n_err++; $display("[TB] FAIL crd0_d_gnt got %b want 0", d_gnt); end
        n_cmp++; if (mem_we !== 4'b0)       begin n_err++; $display("[TB] FAIL crd0_mem_we got %b want 0000", mem_we); end
        n_cmp++; if (mem_addr !== 32'h100)  begin n_err++; $display("[TB] FAIL crd0_addr got %h want 100", mem_addr); end
        @(negedge clk); c_addr = 32'h104; #1;
        n_cmp++; if (c_gnt !== 1'b1)        begin n_err++; $display("[TB] FAIL crd1_c_gnt got %b want 1", c_gnt); end
        n_cmp++; if (c_rvalid !== 1'b1)     begin n_err++; $display("[TB] FAIL crd1_rvalid got %b want 1", c_rvalid); end
        n_cmp++; if (c_rdata !== 32'h1111_2222) begin n_err++; $display("[TB] FAIL crd1_rdata got %h want 11112222", c_rdata); end
        n_cmp++; if (d_rvalid !== 1'b0)     begin n_err++; $display("[TB] FAIL crd1_d_rvalid got %b want 0", d_rvalid); end
        @(negedge clk); c_req = 1'b0; #1;
        n_cmp++; if (c_rvalid !== 1'b1)     begin n_err++; $display("[TB] FAIL crd2_rvalid got %b want 1", c_rvalid); end
        n_cmp++; if (c_rdata !== 32'h3333_4444) begin n_err++; $display("[TB] FAIL crd2_rdata got %h want 33334444", c_rdata); end
        n_cmp++; if (c_gnt !== 1'b0)        begin n_err++; $display("[TB] FAIL crd2_c_gnt got %b want 0", c_gnt); end
        @(negedge clk); #1;
        n_cmp++; if (c_rvalid !== 1'b0)     begin n_err++; $display("[TB] FAIL crd3_rvalid got %b want 0", c_rvalid); end
    endtask

    // Both ports contend continuously: four core grants, then one forced D grant.
    task automatic test_fairness();
        logic exp_d;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            c_req = 1'b1; c_we = 4'b0; c_addr = 32'h100;
            d_req = 1'b1; d_lock = 1'b0; d_we = 4'b0; d_addr = 32'h104;
            #1;
            exp_d = ((k % 5) == 4);
            n_cmp++; if (d_gnt !== exp_d)  begin n_err++; $display("[TB] FAIL fair%0d_d_gnt got %b want %b", k, d_gnt, exp_d); end
            n_cmp++; if (c_gnt !== !exp_d) begin n_err++; $display("[TB] FAIL fair%0d_c_gnt got %b want %b", k, c_gnt, !exp_d); end
            n_cmp++; if (dut.wait_cnt !== 3'(k % 5)) begin n_err++; $display("[TB] FAIL fair%0d_wait got %0d want %0d", k, dut.wait_cnt, k % 5); end
            n_cmp++; if (mem_we !== 4'b0)  begin n_err++; $display("[TB] FAIL fair%0d_mem_we got %b want 0000", k, mem_we); end
            n_cmp++; if (c_rvalid !== (k > 0 && ((k - 1) % 5) != 4)) begin n_err++; $display("[TB] FAIL fair%0d_c_rvalid got %b", k, c_rvalid); end
            n_cmp++; if (d_rvalid !== (k > 0 && ((k - 1) % 5) == 4)) begin n_err++; $display("[TB] FAIL fair%0d_d_rvalid got %b", k, d_rvalid); end
            if (exp_d) begin
                n_cmp++; if (mem_addr !== 32'h104) begin n_err++; $display("[TB] FAIL fair%0d_addr got %h want 104", k, mem_addr); end
            end
        end
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (d_rvalid !== 1'b1) begin n_err++; $display("[TB] FAIL fair_end_d_rvalid got %b want 1", d_rvalid); end
        n_cmp++; if (d_rdata !== 32'h3333_4444) begin n_err++; $display("[TB] FAIL fair_end_d_rdata got %h want 33334444", d_rdata); end
        n_cmp++; if (c_rvalid !== 1'b0) begin n_err++; $display("[TB] FAIL fair_end_c_rvalid got %b want 0", c_rvalid); end
    endtask

    // Locked DMA burst is capped at 8 beats, then the waiting core gets in.
    task automatic test_burst();
        logic exp_d, exp_c, exp_own;
        for (int b = 1; b <= 13; b++) begin
            @(negedge clk);
            d_req = 1'b1; d_lock = 1'b1; d_we = 4'b0; d_addr = 32'h104;
            c_req = (b >= 2); c_we = 4'b0; c_addr = 32'h100;
            #1;
            exp_d   = (b <= 8) || (b == 13);
            exp_c   = (b >= 9) && (b <= 12);
            exp_own = (b >= 2) && (b <= 8);
            n_cmp++; if (d_gnt !== exp_d)       begin n_err++; $display("[TB] FAIL burst%0d_d_gnt got %b want %b", b, d_gnt, exp_d); end
            n_cmp++; if (c_gnt !== exp_c)       begin n_err++; $display("[TB] FAIL burst%0d_c_gnt got %b want %b", b, c_gnt, exp_c); end
            n_cmp++; if (dma_owner !== exp_own) begin n_err++; $display("[TB] FAIL burst%0d_owner got %b want %b", b, dma_owner, exp_own); end
            n_cmp++; if (d_rvalid !== (b >= 2 && b <= 9)) begin n_err++; $display("[TB] FAIL burst%0d_d_rvalid got %b", b, d_rvalid); end
            n_cmp++; if (c_rvalid !== (b >= 10))          begin n_err++; $display("[TB] FAIL burst%0d_c_rvalid got %b", b, c_rvalid); end
        end
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (dma_owner !== 1'b1) begin n_err++; $display("[TB] FAIL burst_tail_owner got %b want 1", dma_owner); end
        n_cmp++; if (d_gnt !== 1'b0)     begin n_err++; $display("[TB] FAIL burst_tail_d_gnt got %b want 0", d_gnt); end
        @(negedge clk); #1;
        n_cmp++; if (dma_owner !== 1'b0) begin n_err++; $display("[TB] FAIL burst_release_owner got %b want 0", dma_owner); end
    endtask

    task automatic test_dma_write();
        @(negedge clk); idle_inputs();
        d_req = 1'b1; d_we = 4'b0011; d_addr = 32'h20; d_wdata = 32'hAABB_CCDD; #1;
        n_cmp++; if (d_gnt !== 1'b1)          begin n_err++; $display("[TB] FAIL dwr_d_gnt got %b want 1", d_gnt); end
        n_cmp++; if (mem_we !== 4'b0011)      begin n_err++; $display("[TB] FAIL dwr_mem_we got %b want 0011", mem_we); end
        n_cmp++; if (mem_addr !== 32'h20)     begin n_err++; $display("[TB] FAIL dwr_addr got %h want 20", mem_addr); end
        n_cmp++; if (mem_din !== 32'hAABB_CCDD) begin n_err++; $display("[TB] FAIL dwr_din got %h want aabbccdd", mem_din); end
        @(negedge clk); idle_inputs(); c_req = 1'b1; c_addr = 32'h20; #1;
        n_cmp++; if (d_rvalid !== 1'b0)       begin n_err++; $display("[TB] FAIL dwr_no_rvalid got %b want 0", d_rvalid); end
        n_cmp++; if (c_gnt !== 1'b1)          begin n_err++; $display("[TB] FAIL dwr_rd_c_gnt got %b want 1", c_gnt); end
        @(negedge clk); c_we = 4'b1111; c_addr = 32'h24; c_wdata = 32'h1234_5678; #1;
        n_cmp++; if (c_rvalid !== 1'b1)       begin n_err++; $display("[TB] FAIL dwr_rd_rvalid got %b want 1", c_rvalid); end
        n_cmp++; if (c_rdata !== 32'h0000_CCDD) begin n_err++; $display("[TB] FAIL dwr_rd_data got %h want 0000ccdd", c_rdata); end
        n_cmp++; if (mem_we !== 4'b1111)      begin n_err++; $display("[TB] FAIL cwr_mem_we got %b want 1111", mem_we); end
        @(negedge clk); c_we = 4'b0; #1;
        n_cmp++; if (c_rvalid !== 1'b0)       begin n_err++; $display("[TB] FAIL cwr_no_rvalid got %b want 0", c_rvalid); end
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (c_rdata !== 32'h1234_5678) begin n_err++; $display("[TB] FAIL cwr_rd_data got %h want 12345678", c_rdata); end
    endtask

    // DMA owner drops its request while the core waits: core gets in that cycle.
    task automatic test_lock_drop();
        @(negedge clk); idle_inputs(); d_req = 1'b1; d_lock = 1'b1; d_addr = 32'h104; #1;
        n_cmp++; if (d_gnt !== 1'b1)     begin n_err++; $display("[TB] FAIL ldrop0_d_gnt got %b want 1", d_gnt); end
        @(negedge clk); c_req = 1'b1; c_we = 4'b1111; c_addr = 32'h40; c_wdata = 32'hDEAD_BEEF; #1;
        n_cmp++; if (d_gnt !== 1'b1)     begin n_err++; $display("[TB] FAIL ldrop1_d_gnt got %b want 1", d_gnt); end
        n_cmp++; if (c_gnt !== 1'b0)     begin n_err++; $display("[TB] FAIL ldrop1_c_gnt got %b want 0", c_gnt); end
        n_cmp++; if (mem_we !== 4'b0)    begin n_err++; $display("[TB] FAIL ldrop1_mem_we got %b want 0000", mem_we); end
        n_cmp++; if (dma_owner !== 1'b1) begin n_err++; $display("[TB] FAIL ldrop1_owner got %b want 1", dma_owner); end
        n_cmp++; if (dut.burst_cnt !== 3'd1) begin n_err++; $display("[TB] FAIL ldrop1_burst got %0d want 1", dut.burst_cnt); end
        @(negedge clk); d_req = 1'b0; #1;
        n_cmp++; if (c_gnt !== 1'b1)     begin n_err++; $display("[TB] FAIL ldrop2_c_gnt got %b want 1", c_gnt); end
        n_cmp++; if (d_gnt !== 1'b0)     begin n_err++; $display("[TB] FAIL ldrop2_d_gnt got %b want 0", d_gnt); end
        n_cmp++; if (mem_we !== 4'b1111) begin n_err++; $display("[TB] FAIL ldrop2_mem_we got %b want 1111", mem_we); end
        n_cmp++; if (mem_addr !== 32'h40) begin n_err++; $display("[TB] FAIL ldrop2_addr got %h want 40", mem_addr); end
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (dma_owner !== 1'b0) begin n_err++; $display("[TB] FAIL ldrop3_owner got %b want 0", dma_owner); end
        n_cmp++; if (dut.burst_cnt !== 3'd0) begin n_err++; $display("[TB] FAIL ldrop3_burst got %0d want 0", dut.burst_cnt); end
        n_cmp++; if (c_rvalid !== 1'b0)  begin n_err++; $display("[TB] FAIL ldrop3_c_rvalid got %b want 0", c_rvalid); end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk); idle_inputs(); d_req = 1'b1; d_lock = 1'b1; d_addr = 32'h100; #1;
        n_cmp++; if (d_gnt !== 1'b1)     begin n_err++; $display("[TB] FAIL rinf0_d_gnt got %b want 1", d_gnt); end
        @(negedge clk); rst = 1'b1; c_req = 1'b1; #1;
        n_cmp++; if (d_rvalid !== 1'b1)  begin n_err++; $display("[TB] FAIL rinf1_d_rvalid got %b want 1", d_rvalid); end
        n_cmp++; if (dma_owner !== 1'b1) begin n_err++; $display("[TB] FAIL rinf1_owner got %b want 1", dma_owner); end
        @(negedge clk); rst = 1'b0; idle_inputs(); c_req = 1'b1; c_addr = 32'h104; #1;
        n_cmp++; if (d_rvalid !== 1'b0)  begin n_err++; $display("[TB] FAIL rinf2_d_rvalid got %b want 0", d_rvalid); end
        n_cmp++; if (dma_owner !== 1'b0) begin n_err++; $display("[TB] FAIL rinf2_owner got %b want 0", dma_owner); end
        n_cmp++; if (dut.burst_cnt !== 3'd0) begin n_err++; $display("[TB] FAIL rinf2_burst got %0d want 0", dut.burst_cnt); end
        n_cmp++; if (dut.wait_cnt !== 3'd0)  begin n_err++; $display("[TB] FAIL rinf2_wait got %0d want 0", dut.wait_cnt); end
        n_cmp++; if (c_gnt !== 1'b1)     begin n_err++; $display("[TB] FAIL rinf2_c_gnt got %b want 1", c_gnt); end
        @(negedge clk); idle_inputs(); #1;
        n_cmp++; if (c_rvalid !== 1'b1)  begin n_err++; $display("[TB] FAIL rinf3_c_rvalid got %b want 1", c_rvalid); end
        n_cmp++; if (c_rdata !== 32'h3333_4444) begin n_err++; $display("[TB] FAIL rinf3_rdata got %h want 33334444", c_rdata); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_core_reads();
        test_fairness();
        test_burst();
        test_dma_write();
        test_lock_drop();
        test_reset_inflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
